kp_scanner: RTL and testbench

Sequential keypad front end for the room terminal's 4x4 matrix keypad. It drives the column lines one at a time and reads the row lines through a synchronizer. It debounces both press and release, and emits a single-cycle strobe carrying the 4-bit key code. It replaces direct combinational use of raw pad signals, and downstream logic consumes only `key_valid`/`key_num`.

---
 rtl/kp_scanner.sv | 163 ++++++++++++++++
 tb/tb_kp_scanner.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kp_scanner.sv
// kp_scanner: 4x4 matrix keypad scanner with press and release debounce.
// Drives one column at a time and emits a one-cycle strobe per accepted key.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   kpr[3:0]  in   row lines, active-low, asynchronous to clk
//   kpc[3:0]  out  column drive, one-hot active-low
//   key_valid out  one-cycle pulse when a debounced press is accepted
//   key_num   out  code of the last accepted key, held until the next accept
//   key_held  out  high from accept until the release is debounced
module kp_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] kpr,
    output logic [3:0] kpc,
    output logic       key_valid,
    output logic [3:0] key_num,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE);

    localparam logic [DW-1:0] DWELL_MAX = DW'(SCAN_DIV - 1);
    // rs lags kpc by two flops; earlier matches may belong to the old column
    localparam logic [DW-1:0] DWELL_MIN = DW'(3);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE - 1);

    localparam logic [3:0] NONE = 4'b1111;

    typedef enum logic [1:0] {
        SCAN,
        DEB,
        HELD,
        REL
    } state_t;

    state_t        state;
    logic [3:0]    s1;
    logic [3:0]    rs;
    logic [3:0]    cand;
    logic [DW-1:0] dwell;
    logic [CW-1:0] cnt;

    // exactly one row pulled low
    function automatic logic one_row(input logic [3:0] p);
        return (p == 4'b0111) || (p == 4'b1011) ||
               (p == 4'b1101) || (p == 4'b1110);
    endfunction

    function automatic logic [1:0] line_idx(input logic [3:0] p);
        logic [1:0] i;
        unique case (p)
            4'b0111: i = 2'd0;
            4'b1011: i = 2'd1;
            4'b1101: i = 2'd2;
            default: i = 2'd3;
        endcase
        return i;
    endfunction

    // keypad legend: column index, then row index
    function automatic logic [3:0] key_code(input logic [1:0] c,
                                            input logic [1:0] r);
        logic [3:0] k;
        unique case ({c, r})
            4'h0: k = 4'd1;
            4'h1: k = 4'd4;
            4'h2: k = 4'd7;
            4'h3: k = 4'd14;
            4'h4: k = 4'd2;
            4'h5: k = 4'd5;
            4'h6: k = 4'd8;
            4'h7: k = 4'd0;
            4'h8: k = 4'd3;
            4'h9: k = 4'd6;
            4'hA: k = 4'd9;
            4'hB: k = 4'd15;
            4'hC: k = 4'd10;
            4'hD: k = 4'd11;
            4'hE: k = 4'd12;
            default: k = 4'd13;
        endcase
        return k;
    endfunction

    logic [3:0] kpc_next;
    logic [3:0] code;

    assign kpc_next = {kpc[0], kpc[3:1]};
    assign code     = key_code(line_idx(kpc), line_idx(cand));

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= NONE;
            rs        <= NONE;
            cand      <= NONE;
            state     <= SCAN;
            dwell     <= '0;
            cnt       <= '0;
            kpc       <= 4'b0111;
            key_valid <= 1'b0;
            key_num   <= 4'd0;
            key_held  <= 1'b0;
        end else begin
            s1        <= kpr;
            rs        <= s1;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell >= DWELL_MIN && one_row(rs)) begin
                        cand  <= rs;
                        cnt   <= '0;
                        state <= DEB;
                    end else if (dwell == DWELL_MAX) begin
                        dwell <= '0;
                        kpc   <= kpc_next;
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                DEB: begin
                    if (rs != cand) begin
                        dwell <= '0;
                        state <= SCAN;
                    end else if (cnt == CNT_MAX) begin
                        key_num   <= code;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= HELD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (rs == NONE) begin
                        cnt   <= '0;
                        state <= REL;
                    end
                end
                REL: begin
                    // a bounce sends us back to HELD without a new strobe
                    if (rs != NONE) begin
                        state <= HELD;
                    end else if (cnt == CNT_MAX) begin
                        dwell    <= '0;
                        kpc      <= kpc_next;
                        key_held <= 1'b0;
                        state    <= SCAN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_kp_scanner.sv
// tb_kp_scanner: scoreboard bench for kp_scanner with a keypad model.
// Expected key codes are queued at press time and checked on each strobe.
module tb_kp_scanner;

    localparam int SD = 8;
    localparam int DB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] kpr;
    logic [3:0] kpc;
    logic       key_valid;
    logic [3:0] key_num;
    logic       key_held;

    kp_scanner #(
        .SCAN_DIV(SD),
        .DEBOUNCE(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .kpr      (kpr),
        .kpc      (kpc),
        .key_valid(key_valid),
        .key_num  (key_num),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int exp_q[$];

    bit         pressed = 1'b0;
    int         key = 0;
    int         pci = 0;
    logic [3:0] pcol = 4'hF;
    logic [3:0] prow = 4'hF;
    bit         frc = 1'b0;
    logic [3:0] frc_val = 4'hF;

    function automatic logic [3:0] pat(int i);
        logic [3:0] one;
        one = 4'b1000;
        return ~(one >> i);
    endfunction

    function automatic int code_at(int c, int r);
        int t[4][4];
        t = '{'{1, 4, 7, 14}, '{2, 5, 8, 0}, '{3, 6, 9, 15}, '{10, 11, 12, 13}};
        return t[c][r];
    endfunction

    // keypad: the pressed key shorts its row to the column being driven
    always_comb begin
        kpr = 4'hF;
        if (frc)
            kpr = frc_val;
        else if (pressed && kpc == pcol)
            kpr = prow;
    end

    task automatic check(string name, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(int k);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (code_at(c, r) == k) begin
                    pci  = c;
                    pcol = pat(c);
                    prow = pat(r);
                end
        key = k;
        pressed = 1'b1;
    endtask

    task automatic wait_strobe();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (key_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("strobe_seen", seen, 1);
    endtask

    // release while HELD: key_held must fall exactly DB+3 edges later
    task automatic release_check();
        check("col_frozen", kpc, pcol);
        check("num_hold", key_num, key);
        pressed = 1'b0;
        tick(DB + 2);
        check("held_before_fall", key_held, 1);
        tick(1);
        check("held_fall", key_held, 0);
        check("next_col", kpc, pat((pci + 1) % 4));
    endtask

    task automatic wait_col(int c);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (kpc == pat(c)) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        check("col_reached", ok, 1);
    endtask

    bit prev_v = 1'b0;

    always @(negedge clk) begin
        if (key_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe key_num=%0d want=none",
                         key_num);
            end else begin
                check("key_num", key_num, exp_q.pop_front());
            end
            check("held_with_strobe", key_held, 1);
            check("no_double_strobe", prev_v, 0);
        end
        prev_v <= key_valid;
    end

    initial begin
        int changes;
        int k;
        bit early;
        logic [3:0] last;
        int li;

        reset = 1'b1;
        tick(3);
        reset = 1'b0;

        // reset state and free-running scan
        check("rst_kpc", kpc, 4'b0111);
        check("rst_valid", key_valid, 0);
        check("rst_num", key_num, 0);
        check("rst_held", key_held, 0);
        tick(SD - 1);
        check("dwell_hold", kpc, pat(0));
        tick(1);
        check("scan_step", kpc, pat(1));
        for (int s = 2; s <= 5; s++) begin
            tick(SD);
            check("scan_step", kpc, pat(s % 4));
        end

        // clean long press of key 0
        press(0);
        exp_q.push_back(0);
        wait_strobe();
        tick(150);
        release_check();
        tick(10);

        // glitching press of key 15, never stable long enough
        press(15);
        pressed = 1'b0;
        wait_col(2);
        for (int i = 0; i < 10; i++) begin
            pressed = 1'($urandom_range(0, 1));
            tick(1);
        end
        pressed = 1'b0;
        tick(3);
        last = kpc;
        li = 0;
        for (int i = 0; i < 4; i++)
            if (pat(i) == last) li = i;
        changes = 0;
        for (int i = 0; i < SD + 4; i++) begin
            tick(1);
            if (kpc != last) begin
                changes = 1;
                break;
            end
        end
        check("glitch_scan_resumes", changes, 1);
        check("glitch_next_col", kpc, pat((li + 1) % 4));

        // release bounce on key 7
        press(7);
        exp_q.push_back(7);
        wait_strobe();
        tick(10);
        pressed = 1'b0;
        tick(6);
        pressed = 1'b1;
        tick(5);
        check("held_in_bounce", key_held, 1);
        release_check();
        tick(10);

        // two rows at once never counts as a press
        wait_col(0);
        frc = 1'b1;
        frc_val = 4'b0011;
        changes = 0;
        last = kpc;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (kpc != last) changes++;
            last = kpc;
        end
        check("multirow_scans", changes >= 10, 1);
        frc = 1'b0;
        tick(3);
        press(13);
        exp_q.push_back(13);
        wait_strobe();
        tick(20);
        release_check();

        // random presses
        for (int n = 0; n < 12; n++) begin
            tick($urandom_range(0, 20));
            k = $urandom_range(0, 15);
            press(k);
            exp_q.push_back(k);
            wait_strobe();
            tick($urandom_range(0, 30));
            release_check();
        end

        // reset while HELD on key 9, then a fresh press of key 1
        tick(5);
        press(9);
        exp_q.push_back(9);
        wait_strobe();
        tick(5);
        press(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_mid_num", key_num, 0);
        check("rst_mid_held", key_held, 0);
        check("rst_mid_kpc", kpc, 4'b0111);
        check("rst_mid_valid", key_valid, 0);
        exp_q.push_back(1);
        early = 1'b0;
        for (int i = 1; i < 20; i++) begin
            tick(1);
            if (key_valid) early = 1'b1;
        end
        check("no_early_strobe", early, 0);
        tick(1);
        check("fresh_strobe", key_valid, 1);
        check("fresh_num", key_num, 1);
        tick(1);
        check("strobe_one_cycle", key_valid, 0);
        release_check();

        tick(5);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
